chacha_aead_seq: RTL and testbench
==================================

# chacha_aead_seq

Job-level sequencer in front of `chacha20_poly1305_core`. It accepts one AEAD job (key, nonce, direction, block count) and drives the core's init/next/done pulse protocol. It streams 512-bit blocks from an upstream valid/ready source through the core to a downstream valid/ready sink, then returns the 128-bit tag. Bounded waits on the core report a timeout error instead of hanging the datapath.

## Interface
- `LEN_W`, 8: width of block-count field; max job = 2^LEN_W−1 blocks.
- `TMO`, 1024: max cycles spent waiting on any core response before abort.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `job_start` in 1: start pulse; accepted only in IDLE.
- `job_len` in LEN_W: block count; 0 = illegal.
- `job_encdec`, `job_key`, `job_nonce` in 1/256/96: job configuration, sampled on accept.
- `job_busy` out 1: high in every state except IDLE.
- `job_err` out 1: one-cycle pulse on illegal length or timeout.
- `in_valid`/`in_ready`/`in_data` in/out/in 1/1/512: upstream plaintext/ciphertext blocks.
- `out_valid`/`out_ready`/`out_data` out/in/out 1/1/512: processed blocks.
- `tag_valid` out 1, `tag_out` out 128: one-cycle tag strobe with value.
- `core_init`, `core_next`, `core_done` out 1: single-cycle pulses to the core.
- `core_encdec`/`core_key`/`core_nonce`/`core_data_in` out 1/256/96/512: registered core config and data.
- `core_ready`, `core_valid`, `core_tag_ok` in 1; `core_data_out` in 512; `core_tag` in 128.

## Operation
- States: IDLE, INIT, WAIT_RDY, FETCH, NEXT, WAIT_VAL, EMIT, DONE, WAIT_TAG, ERR.
- IDLE: on `job_start`, if `job_len`==0 → ERR; else latch config, clear `blk_cnt`, → INIT.
- INIT: `core_init`=1 for exactly one cycle → WAIT_RDY.
- WAIT_RDY: on `core_ready` → FETCH.
- FETCH: `in_ready`=1. On `in_valid&in_ready`, capture `in_data` into `core_data_in` → NEXT.
- NEXT: `core_next`=1 for one cycle → WAIT_VAL.
- WAIT_VAL: on `core_valid`, capture `core_data_out` into the output register, `blk_cnt`++ → EMIT.
- EMIT: `out_valid`=1, data held stable until `out_ready`. On handshake: if `blk_cnt`==`job_len` → DONE, else → FETCH.
- DONE: `core_done`=1 for one cycle → WAIT_TAG.
- WAIT_TAG: on `core_tag_ok`, `tag_valid`=1 with `tag_out`=`core_tag` (same cycle, combinational from registered capture next cycle is NOT used) → IDLE.
- ERR: `job_err`=1 for one cycle → IDLE. The core is left as-is; the next job re-inits it.
- Timeout: `tmo_cnt` clears on every state change and increments in WAIT_RDY, WAIT_VAL and WAIT_TAG. At `tmo_cnt`==TMO−1 without the awaited input → ERR.
- `job_start` while busy is ignored, with no error.
- `out_ready` backpressure stalls only EMIT; no timeout applies in EMIT or FETCH.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, data and config registers 0.
- Reset mid-job: immediate return to IDLE, all outputs 0; the partial job is lost.
- Minimum per-block overhead beyond core latency: FETCH 1, NEXT 1, WAIT_VAL ≥1, EMIT 1, so ≥4 cycles per block.
- `job_start` → `core_init` high: 1 cycle. `in` handshake → `core_next` high: 1 cycle. `core_valid` → `out_valid` high: 1 cycle.
- `core_tag_ok` → `tag_valid`: 0 cycles (same cycle). `job_busy` drops the following cycle.
- `blk_cnt` is LEN_W bits and never wraps, because `job_len` ≤ 2^LEN_W−1.

## Structure
- `chacha_seq_pkg`: state enum, KEY_W=256, NONCE_W=96, BLK_W=512, TAG_W=128.
- One sub-module, `seq_timeout`: a TMO-parameterised counter with `clr`/`en`/`expired`.
- Everything else stays in a single FSM file.

## Test plan
- Single block: `job_len`=1, `in_data`={8{64'hcafebabedeadbeef}}, model core ready after 3 cycles and valid after 10 → exactly one each of `core_init`/`core_next`/`core_done` pulses, one `out_valid` carrying model data, `tag_valid` once, `job_busy` low afterwards.
- Three blocks with `out_ready` held low for 5 cycles on block 2 → `out_data` stable throughout the stall, `core_next` count = 3, blocks emitted in order.
- `job_len`=0 → `job_err` pulse 1 cycle after start, no `core_*` pulses, `job_busy` high for one cycle only.
- Core never asserts `core_valid` with TMO=16 → `job_err` exactly 16 cycles after entering WAIT_VAL, then IDLE; the next job completes normally.
- `rst` asserted during WAIT_TAG → all outputs 0 immediately; a `job_start` issued while busy earlier was ignored.

Source files
------------

// File: rtl/chacha_seq_pkg.sv
// Shared types and widths for the ChaCha20-Poly1305 job sequencer.
package chacha_seq_pkg;

  localparam int KEY_W   = 256;
  localparam int NONCE_W = 96;
  localparam int BLK_W   = 512;
  localparam int TAG_W   = 128;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_RDY,
    ST_FETCH,
    ST_NEXT,
    ST_WAIT_VAL,
    ST_EMIT,
    ST_DONE,
    ST_WAIT_TAG,
    ST_ERR
  } seq_state_e;

  // States in which the sequencer is blocked on a core response.
  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_WAIT_RDY) || (s == ST_WAIT_VAL) || (s == ST_WAIT_TAG);
  endfunction

endpackage

// File: rtl/chacha_aead_seq_timeout.sv
// Bounded-wait counter: counts enabled cycles, flags the last allowed one.
module seq_timeout #(
  parameter int TMO = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] LAST = CW'(TMO - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has priority; counting saturates at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/chacha_aead_seq.sv
// Job-level sequencer driving the chacha20_poly1305_core init/next/done
// protocol and streaming blocks between valid/ready source and sink.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | waiting for job_start
// INIT      | core_init pulse
// WAIT_RDY  | waiting for core_ready (timed)
// FETCH     | in_ready high, waiting for an input block
// NEXT      | core_next pulse for the captured block
// WAIT_VAL  | waiting for core_valid (timed)
// EMIT      | out_valid high, holding block until out_ready
// DONE      | core_done pulse
// WAIT_TAG  | waiting for core_tag_ok (timed), tag passed through
// ERR       | job_err pulse
module chacha_aead_seq
  import chacha_seq_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int TMO   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_start,
  input  logic [LEN_W-1:0]   job_len,
  input  logic               job_encdec,
  input  logic [KEY_W-1:0]   job_key,
  input  logic [NONCE_W-1:0] job_nonce,
  output logic               job_busy,
  output logic               job_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLK_W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLK_W-1:0]   out_data,
  output logic               tag_valid,
  output logic [TAG_W-1:0]   tag_out,
  output logic               core_init,
  output logic               core_next,
  output logic               core_done,
  output logic               core_encdec,
  output logic [KEY_W-1:0]   core_key,
  output logic [NONCE_W-1:0] core_nonce,
  output logic [BLK_W-1:0]   core_data_in,
  input  logic               core_ready,
  input  logic               core_valid,
  input  logic               core_tag_ok,
  input  logic [BLK_W-1:0]   core_data_out,
  input  logic [TAG_W-1:0]   core_tag
);

  seq_state_e state_q, state_d;

  logic               encdec_q, encdec_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [BLK_W-1:0]   din_q, din_d;
  logic [BLK_W-1:0]   dout_q, dout_d;

  logic tmo_clr;
  logic tmo_en;
  logic tmo_expired;

  // The wait counter restarts on every state change, runs only while
  // blocked on the core.
  assign tmo_clr = (state_d != state_q);
  assign tmo_en  = is_wait_state(state_q);

  seq_timeout #(
    .TMO(TMO)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Next-state, config latch and datapath capture.
  always_comb begin
    state_d   = state_q;
    encdec_d  = encdec_q;
    key_d     = key_q;
    nonce_d   = nonce_q;
    len_d     = len_q;
    blk_cnt_d = blk_cnt_q;
    din_d     = din_q;
    dout_d    = dout_q;

    case (state_q)
      ST_IDLE: begin
        if (job_start) begin
          if (job_len == '0) begin
            state_d = ST_ERR;
          end else begin
            encdec_d  = job_encdec;
            key_d     = job_key;
            nonce_d   = job_nonce;
            len_d     = job_len;
            blk_cnt_d = '0;
            state_d   = ST_INIT;
          end
        end
      end
      ST_INIT: state_d = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (core_ready) begin
          state_d = ST_FETCH;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_FETCH: begin
        if (in_valid) begin
          din_d   = in_data;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: state_d = ST_WAIT_VAL;
      ST_WAIT_VAL: begin
        if (core_valid) begin
          dout_d    = core_data_out;
          blk_cnt_d = blk_cnt_q + 1'b1;
          state_d   = ST_EMIT;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d = (blk_cnt_q == len_q) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_WAIT_TAG;
      ST_WAIT_TAG: begin
        if (core_tag_ok) begin
          state_d = ST_IDLE;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      encdec_q  <= 1'b0;
      key_q     <= '0;
      nonce_q   <= '0;
      len_q     <= '0;
      blk_cnt_q <= '0;
      din_q     <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      encdec_q  <= encdec_d;
      key_q     <= key_d;
      nonce_q   <= nonce_d;
      len_q     <= len_d;
      blk_cnt_q <= blk_cnt_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
    end
  end

  assign job_busy     = (state_q != ST_IDLE);
  assign job_err      = (state_q == ST_ERR);
  assign in_ready     = (state_q == ST_FETCH);
  assign out_valid    = (state_q == ST_EMIT);
  assign out_data     = dout_q;
  assign core_init    = (state_q == ST_INIT);
  assign core_next    = (state_q == ST_NEXT);
  assign core_done    = (state_q == ST_DONE);
  assign core_encdec  = encdec_q;
  assign core_key     = key_q;
  assign core_nonce   = nonce_q;
  assign core_data_in = din_q;

  // Tag is forwarded in the cycle the core reports it; gated so the bus
  // reads zero whenever no tag is being presented.
  assign tag_valid = (state_q == ST_WAIT_TAG) && core_tag_ok;
  assign tag_out   = tag_valid ? core_tag : '0;

endmodule

// File: tb/tb_chacha_aead_seq.sv
// Self-checking bench for chacha_aead_seq with a behavioural core model.
module tb_chacha_aead_seq;
  import chacha_seq_pkg::*;

  localparam int LEN_W = 8;
  localparam int TMO   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               job_start = 1'b0;
  logic [LEN_W-1:0]   job_len = '0;
  logic               job_encdec = 1'b0;
  logic [KEY_W-1:0]   job_key = '0;
  logic [NONCE_W-1:0] job_nonce = '0;
  logic               job_busy, job_err;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [BLK_W-1:0]   in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [BLK_W-1:0]   out_data;
  logic               tag_valid;
  logic [TAG_W-1:0]   tag_out;
  logic               core_init, core_next, core_done, core_encdec;
  logic [KEY_W-1:0]   core_key;
  logic [NONCE_W-1:0] core_nonce;
  logic [BLK_W-1:0]   core_data_in;
  logic               core_ready = 1'b0, core_valid = 1'b0, core_tag_ok = 1'b0;
  logic [BLK_W-1:0]   core_data_out = '0;
  logic [TAG_W-1:0]   core_tag = '0;

  logic [1512:0] all_out;
  assign all_out = {job_busy, job_err, in_ready, out_valid, out_data, tag_valid, tag_out,
                    core_init, core_next, core_done, core_encdec, core_key, core_nonce,
                    core_data_in};

  always #5 clk = ~clk;

  chacha_aead_seq #(.LEN_W(LEN_W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .job_start(job_start), .job_len(job_len), .job_encdec(job_encdec),
    .job_key(job_key), .job_nonce(job_nonce),
    .job_busy(job_busy), .job_err(job_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tag_valid(tag_valid), .tag_out(tag_out),
    .core_init(core_init), .core_next(core_next), .core_done(core_done),
    .core_encdec(core_encdec), .core_key(core_key), .core_nonce(core_nonce),
    .core_data_in(core_data_in),
    .core_ready(core_ready), .core_valid(core_valid), .core_tag_ok(core_tag_ok),
    .core_data_out(core_data_out), .core_tag(core_tag)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural core transform; the scoreboard uses the bench's own key/dir.
  function automatic logic [BLK_W-1:0] core_model(input logic [BLK_W-1:0] d,
                                                  input logic [KEY_W-1:0] k,
                                                  input logic e);
    logic [BLK_W-1:0] m;
    m = d ^ {k, ~k};
    if (e) m = {m[255:0], m[511:256]};
    return m;
  endfunction

  // ---------------- core model ----------------
  int rdy_dly = 0, val_dly = 0, tag_dly = 0;
  bit no_valid = 0, no_tag = 0;
  logic [TAG_W-1:0] tag_val = '0;

  always @(posedge clk) begin
    #1;
    core_ready  = 1'b0;
    core_valid  = 1'b0;
    core_tag_ok = 1'b0;
    core_tag    = tag_val;
    if (rst) begin
      rdy_dly = 0; val_dly = 0; tag_dly = 0;
    end else begin
      if (rdy_dly > 0) begin rdy_dly--; if (rdy_dly == 0) core_ready = 1'b1; end
      if (val_dly > 0) begin val_dly--; if (val_dly == 0) core_valid = 1'b1; end
      if (tag_dly > 0) begin tag_dly--; if (tag_dly == 0) core_tag_ok = 1'b1; end
      if (core_init) rdy_dly = 3;
      if (core_next && !no_valid) begin
        val_dly = 10;
        core_data_out = core_model(core_data_in, core_key, core_encdec);
      end
      if (core_done && !no_tag) tag_dly = 4;
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int n_init, n_next, n_done, n_err, n_tag, n_stall, n_stab_bad, n_busy, n_busy_after_tag;
  int last_err_cyc, last_next_cyc;
  logic [TAG_W-1:0] last_tag;
  logic [BLK_W-1:0] obs_q[$];
  logic [BLK_W-1:0] exp_q[$];
  bit prev_stall = 0, prev_tag = 0;
  logic [BLK_W-1:0] prev_data;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 0;
      prev_tag   = 0;
    end else begin
      if (core_init) n_init++;
      if (core_next) begin n_next++; last_next_cyc = cyc; end
      if (core_done) n_done++;
      if (job_err) begin n_err++; last_err_cyc = cyc; end
      if (tag_valid) begin n_tag++; last_tag = tag_out; end
      if (job_busy) n_busy++;
      if (prev_tag && job_busy) n_busy_after_tag++;
      if (prev_stall && (!out_valid || out_data != prev_data)) n_stab_bad++;
      if (out_valid && !out_ready) n_stall++;
      if (out_valid && out_ready) obs_q.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = tag_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_init = 0; n_next = 0; n_done = 0; n_err = 0; n_tag = 0; n_stall = 0;
    n_stab_bad = 0; n_busy = 0; n_busy_after_tag = 0;
    last_err_cyc = -1; last_next_cyc = -1; last_tag = '0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic start_job(input logic [LEN_W-1:0] len, input logic [KEY_W-1:0] k,
                           input logic [NONCE_W-1:0] n, input logic e);
    job_len = len; job_key = k; job_nonce = n; job_encdec = e;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
  endtask

  task automatic send_block(input logic [BLK_W-1:0] d, input logic [KEY_W-1:0] k,
                            input logic e);
    bit ok;
    ok = 0;
    in_data  = d;
    in_valid = 1'b1;
    exp_q.push_back(core_model(d, k, e));
    for (int w = 0; w < 400; w++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL send_block: in_ready never seen within 400 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int w = 0; w < 1000; w++) begin
      @(negedge clk);
      if (!job_busy) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_idle: job_busy still 1 after 1000 cycles, required 0", name);
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %0h required 0", all_out);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_release_outputs: got %0h required 0", all_out);
    end
  endtask

  task automatic test_single_block();
    logic [KEY_W-1:0]   k;
    logic [NONCE_W-1:0] n;
    k = {8{32'h1234_5678}};
    n = 96'h0a0b0c0d_0e0f1011_12131415;
    tag_val = 128'hfeedface_0badf00d_11223344_55667788;
    clear_stats();
    start_job(8'd1, k, n, 1'b1);
    send_block({8{64'hcafebabedeadbeef}}, k, 1'b1);
    wait_idle("single");
    n_chk++;
    if (n_init !== 1 || n_next !== 1 || n_done !== 1) begin
      n_fail++;
      $display("FAIL single_pulses: init/next/done = %0d/%0d/%0d required 1/1/1",
               n_init, n_next, n_done);
    end
    n_chk++;
    if (obs_q.size() !== 1) begin
      n_fail++; $display("FAIL single_out_count: got %0d required 1", obs_q.size());
    end else if (obs_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL single_out_data: got %0h required %0h", obs_q[0], exp_q[0]);
    end
    n_chk++;
    if (n_tag !== 1 || last_tag !== tag_val) begin
      n_fail++;
      $display("FAIL single_tag: count %0d value %0h required 1 / %0h", n_tag, last_tag, tag_val);
    end
    n_chk++;
    if (n_busy_after_tag !== 0) begin
      n_fail++; $display("FAIL single_busy_drop: busy after tag %0d required 0", n_busy_after_tag);
    end
    n_chk++;
    if (core_key !== k || core_nonce !== n || core_encdec !== 1'b1) begin
      n_fail++;
      $display("FAIL single_config: key %0h nonce %0h dir %0b required %0h %0h 1",
               core_key, core_nonce, core_encdec, k, n);
    end
  endtask

  task automatic test_three_blocks();
    logic [KEY_W-1:0] k;
    bit ok1, ok2;
    k = {4{64'h0f1e2d3c_4b5a6978}};
    tag_val = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    ok1 = 0; ok2 = 0;
    clear_stats();
    start_job(8'd3, k, 96'h1, 1'b0);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          send_block({16{32'ha5a5_0000 + 32'(i)}}, k, 1'b0);
        end
      end
      begin
        for (int w = 0; w < 400; w++) begin
          @(negedge clk);
          if (obs_q.size() >= 1) begin ok1 = 1; break; end
        end
        tick();
        out_ready = 1'b0;
        for (int w = 0; w < 400; w++) begin
          @(negedge clk);
          if (out_valid) begin ok2 = 1; break; end
        end
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_idle("three");
    n_chk++;
    if (!ok1 || !ok2) begin
      n_fail++; $display("FAIL three_stall_setup: first/second block seen %0b/%0b required 1/1", ok1, ok2);
    end
    n_chk++;
    if (n_next !== 3) begin
      n_fail++; $display("FAIL three_next_count: got %0d required 3", n_next);
    end
    n_chk++;
    if (n_stall !== 5 || n_stab_bad !== 0) begin
      n_fail++;
      $display("FAIL three_stall: stall cycles %0d unstable %0d required 5 / 0", n_stall, n_stab_bad);
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL three_block%0d: missing output, got %0d blocks", i, obs_q.size());
      end else begin
        logic [BLK_W-1:0] o, e;
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL three_block%0d: got %0h required %0h", i, o, e);
        end
      end
    end
    n_chk++;
    if (n_tag !== 1 || last_tag !== tag_val || n_done !== 1) begin
      n_fail++;
      $display("FAIL three_tag: tags %0d done %0d value %0h required 1 1 %0h",
               n_tag, n_done, last_tag, tag_val);
    end
  endtask

  task automatic test_len_zero();
    int st_cyc;
    clear_stats();
    st_cyc = cyc;
    start_job(8'd0, '1, '1, 1'b1);
    repeat (5) tick();
    n_chk++;
    if (n_err !== 1 || last_err_cyc !== st_cyc + 2) begin
      n_fail++;
      $display("FAIL len0_err: pulses %0d at cycle %0d required 1 at %0d",
               n_err, last_err_cyc, st_cyc + 2);
    end
    n_chk++;
    if (n_init + n_next + n_done !== 0) begin
      n_fail++; $display("FAIL len0_core_pulses: got %0d required 0", n_init + n_next + n_done);
    end
    n_chk++;
    if (n_busy !== 1) begin
      n_fail++; $display("FAIL len0_busy: busy cycles %0d required 1", n_busy);
    end
  endtask

  task automatic test_timeout();
    logic [KEY_W-1:0] k;
    k = {8{32'h7777_aaaa}};
    tag_val = 128'hdead_0000_beef_1111_2222_3333_4444_5555;
    clear_stats();
    no_valid = 1;
    start_job(8'd1, k, 96'h2, 1'b1);
    send_block({16{32'h3c3c_c3c3}}, k, 1'b1);
    wait_idle("timeout");
    no_valid = 0;
    n_chk++;
    if (n_err !== 1 || last_err_cyc - last_next_cyc !== 17) begin
      n_fail++;
      $display("FAIL timeout_err: pulses %0d, cycles from WAIT_VAL entry %0d required 1 / 16",
               n_err, last_err_cyc - last_next_cyc - 1);
    end
    n_chk++;
    if (n_done !== 0 || n_tag !== 0 || obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL timeout_abort: done %0d tag %0d out %0d required 0 0 0",
               n_done, n_tag, obs_q.size());
    end
    clear_stats();
    start_job(8'd2, k, 96'h3, 1'b0);
    send_block({8{64'h0102_0304_0506_0708}}, k, 1'b0);
    send_block({8{64'h1111_2222_3333_4444}}, k, 1'b0);
    wait_idle("after_timeout");
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL recover_block%0d: missing output, got %0d blocks", i, obs_q.size());
      end else begin
        logic [BLK_W-1:0] o, e;
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL recover_block%0d: got %0h required %0h", i, o, e);
        end
      end
    end
    n_chk++;
    if (n_tag !== 1 || last_tag !== tag_val || n_err !== 0) begin
      n_fail++;
      $display("FAIL recover_tag: tags %0d err %0d value %0h required 1 0 %0h",
               n_tag, n_err, last_tag, tag_val);
    end
  endtask

  task automatic test_reset_mid();
    logic [KEY_W-1:0] k;
    bit ok;
    k = {8{32'h5555_1234}};
    ok = 0;
    clear_stats();
    no_tag = 1;
    start_job(8'd1, k, 96'h4, 1'b1);
    send_block({16{32'h9999_0000}}, k, 1'b1);
    job_len = 8'd0;
    job_key = '1;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    for (int w = 0; w < 400; w++) begin
      @(negedge clk);
      if (n_done == 1) begin ok = 1; break; end
    end
    repeat (3) tick();
    n_chk++;
    if (!ok || n_err !== 0 || n_init !== 1 || core_key !== k || !job_busy) begin
      n_fail++;
      $display("FAIL busy_start_ignored: done_seen %0b err %0d init %0d busy %0b key %0h required 1 0 1 1 %0h",
               ok, n_err, n_init, job_busy, core_key, k);
    end
    n_chk++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL midreset_block: got %0d blocks required 1 matching", obs_q.size());
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %0h required 0", all_out);
    end
    repeat (2) tick();
    rst = 1'b0;
    no_tag = 0;
    repeat (2) tick();
    n_chk++;
    if (all_out !== '0 || n_tag !== 0) begin
      n_fail++; $display("FAIL midreset_idle: outputs %0h tags %0d required 0 0", all_out, n_tag);
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_single_block();
    test_three_blocks();
    test_len_zero();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
